// File: rtl/mem_access_unit.sv
// MEM-stage data-memory sequencer: one cache request per instruction, stalls until
// the response, with byte-lane steering for stores and byte extraction for loads.
module mem_access_unit #(
  parameter int unsigned WATCHDOG_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_byte_enable,
  input  logic        stb_filter_enable,
  input  logic        regfile_filter_enable,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic        advance,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [1:0]  dmem_byte_enable,
  output logic [15:0] dmem_address,
  output logic [15:0] dmem_wdata,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic [15:0] rdata_out,
  output logic        stall,
  output logic        error
);

  typedef enum logic [1:0] {StIdle, StAccess, StHold} state_e;

  state_e      state_q, state_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [1:0]  be_q, be_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        byte_load_q, byte_load_d;
  logic        byte_hi_q, byte_hi_d;
  logic [15:0] rdata_q, rdata_d;
  logic        error_q, error_d;
  logic [15:0] wdog_q, wdog_d;
  logic        req;

  assign req = valid & (mem_read | mem_write);

  always_comb begin
    state_d     = state_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    be_d        = be_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    byte_load_d = byte_load_q;
    byte_hi_d   = byte_hi_q;
    rdata_d     = rdata_q;
    error_d     = error_q;
    wdog_d      = wdog_q;
    stall       = 1'b0;
    unique case (state_q)
      StIdle: begin
        stall = req;
        if (req) begin
          state_d     = StAccess;
          // A simultaneous read+write resolves to the write.
          wr_d        = mem_write;
          rd_d        = mem_read & ~mem_write;
          addr_d      = {addr[15:1], 1'b0};
          byte_load_d = regfile_filter_enable;
          byte_hi_d   = addr[0];
          if (stb_filter_enable) begin
            wdata_d = {wdata[7:0], wdata[7:0]};
            be_d    = addr[0] ? 2'b10 : 2'b01;
          end else begin
            wdata_d = wdata;
            be_d    = mem_byte_enable;
          end
        end
      end
      StAccess: begin
        stall = 1'b1;
        if (dmem_resp) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          wdog_d  = '0;
          state_d = StHold;
          if (rd_q) begin
            rdata_d = byte_load_q ?
                      {8'h00, (byte_hi_q ? dmem_rdata[15:8] : dmem_rdata[7:0])} : dmem_rdata;
          end
        end else begin
          // Saturate so a hung cache never wraps the count back below the threshold.
          if (wdog_q != 16'hFFFF) wdog_d = wdog_q + 16'd1;
          if (({1'b0, wdog_q} + 17'd1) >= 17'(WATCHDOG_CYCLES)) error_d = 1'b1;
        end
      end
      StHold: begin
        if (advance) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      be_q        <= 2'b00;
      addr_q      <= '0;
      wdata_q     <= '0;
      byte_load_q <= 1'b0;
      byte_hi_q   <= 1'b0;
      rdata_q     <= '0;
      error_q     <= 1'b0;
      wdog_q      <= '0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      be_q        <= be_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      byte_load_q <= byte_load_d;
      byte_hi_q   <= byte_hi_d;
      rdata_q     <= rdata_d;
      error_q     <= error_d;
      wdog_q      <= wdog_d;
    end
  end

  assign dmem_read        = rd_q;
  assign dmem_write       = wr_q;
  assign dmem_byte_enable = be_q;
  assign dmem_address     = addr_q;
  assign dmem_wdata       = wdata_q;
  assign rdata_out        = rdata_q;
  assign error            = error_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM-stage data-memory sequencer for the pipelined LC-3b. It consumes the memory fields of the control word produced by control_rom after they have travelled down the pipeline: mem_read, mem_write, mem_byte_enable, stb_filter_enable and regfile_filter_enable. It issues one request per instruction to the data cache over a read/write/resp handshake and stalls the pipeline until the response arrives. It also applies byte-lane steering for STB and byte extraction for LDB, and hands the load data to the WB stage.

Parameters:
WATCHDOG_CYCLES, 255, number of ACCESS cycles without dmem_resp before the sticky error flag is set (1..65535).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- valid  in  1  the MEM stage holds a live instruction.
- mem_read  in  1  ctrl.mem_read.
- mem_write  in  1  ctrl.mem_write.
- mem_byte_enable  in  2  ctrl.mem_byte_enable.
- stb_filter_enable  in  1  byte store.
- regfile_filter_enable  in  1  byte load, zero-extended.
- addr  in  16  effective address (MAR value).
- wdata  in  16  store data (MDR value).
- advance  in  1  global pipeline enable; MEM→WB transfers this cycle.
- dmem_read  out  1  cache read strobe.
- dmem_write  out  1  cache write strobe.
- dmem_byte_enable  out  2  cache lane enables.
- dmem_address  out  16  word-aligned cache address.
- dmem_wdata  out  16  cache write data.
- dmem_rdata  in  16  cache read data.
- dmem_resp  in  1  cache completion, one cycle per request.
- rdata_out  out  16  filtered load result, held until the next capture.
- stall  out  1  MEM stage not ready.
- error  out  1  sticky watchdog flag.

Behaviour:
- States: IDLE, ACCESS, HOLD. Reset forces IDLE. The following all clear to 0 on reset: dmem_read, dmem_write, dmem_address, dmem_wdata, rdata_out, error, the watchdog counter, and the latched request registers. dmem_byte_enable resets to 2'b00.
- Request qualification:
  - req = valid & (mem_read | mem_write).
  - If mem_read and mem_write are both 1, the write is performed and the read is ignored.
- IDLE:
  - If req, latch the request (address, data, lanes, kind, filter flags) and go to ACCESS.
  - stall = req (combinational), so the pipeline freezes in the same cycle the request is seen.
  - If there is no req, stall = 0.
- ACCESS:
  - Drive dmem_read or dmem_write from the latched registers; all request fields stay stable every cycle until dmem_resp.
  - stall = 1.
  - The watchdog increments every cycle. When it reaches WATCHDOG_CYCLES, set error; error stays set until reset. The request continues to be driven after error is set.
  - On dmem_resp: drop the strobes in the next cycle, capture rdata_out if the request was a read, clear the watchdog, and go to HOLD.
  - Minimum latency is 2 cycles from req to stall deasserting (1-cycle cache response).
- HOLD:
  - stall = 0.
  - If advance, go to IDLE. The next instruction is evaluated the following cycle, so the same instruction is never reissued.
  - If not advance, remain in HOLD and issue nothing.
- Addressing: dmem_address = {addr[15:1], 1'b0}. Word accesses with addr[0]=1 are silently aligned.
- Byte store (stb_filter_enable = 1):
  - dmem_wdata = {wdata[7:0], wdata[7:0]}.
  - dmem_byte_enable = 2'b10 if addr[0] = 1, else 2'b01.
- Otherwise dmem_byte_enable = mem_byte_enable and dmem_wdata = wdata.
- Byte load (regfile_filter_enable = 1): rdata_out = {8'h00, addr[0] ? dmem_rdata[15:8] : dmem_rdata[7:0]}.
- Word load: rdata_out = dmem_rdata.
- dmem_resp outside ACCESS is ignored.
- Input changes on valid, addr or the control fields while in ACCESS are ignored, because the latched copy drives the cache.
- Reset asserted mid-ACCESS drops the strobes immediately (asynchronously). The outstanding cache response after reset is ignored.

Test Plan:
1. LDW: addr=16'h1234, dmem_resp on the 3rd ACCESS cycle with rdata=16'hBEEF → dmem_address=16'h1234 and dmem_read high for exactly 3 cycles; stall high 4 cycles; rdata_out=16'hBEEF; stall low on the next cycle.
2. STB: addr=16'h2001, wdata=16'h00A5 → dmem_write=1, dmem_address=16'h2000, dmem_byte_enable=2'b10, dmem_wdata=16'hA5A5.
3. LDB: addr=16'h3003, dmem_rdata=16'h7F80, 1-cycle resp → rdata_out=16'h007F. Repeat with addr=16'h3002 → rdata_out=16'h0080.
4. Back-to-back loads with advance held low 2 cycles in HOLD → no strobe during HOLD; the second request starts only after advance, and the first is issued exactly once.
5. WATCHDOG_CYCLES=4, no dmem_resp → error rises after the 4th ACCESS cycle and stays high; a late resp completes the access; error is cleared only by reset.
6. Reset asserted mid-ACCESS with both mem_read and mem_write set → strobes drop asynchronously and state is IDLE; after release, the re-presented request issues dmem_write=1 and dmem_read=0.
